// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin packet arbiter sharing one FIFO write port among N_REQ requesters.
// Define ARB_WDOG_EN to release a grant whose owner stalls for WDOG_CYC cycles (pulses wdog_err).
//
// state | meaning
// IDLE  | no grant held; arbitrate among valid requesters, register the winner
// BUSY  | grant held for gidx until its last beat is accepted (or watchdog trips)

module fifo_write_arbiter #(
    parameter int N_REQ    = 4,
    parameter int DATA_W   = 8,
    parameter int GNT_W    = 2,
    parameter int WDOG_CYC = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ-1:0]        req_last,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    input  logic                    wfull,
    output logic [N_REQ-1:0]        req_ack,
    output logic [N_REQ-1:0]        gnt,
    output logic                    winc,
    output logic [DATA_W-1:0]       wdata,
    output logic                    busy,
    output logic                    wdog_err
);

    if (N_REQ < 2 || N_REQ > 8 || GNT_W != $clog2(N_REQ) || WDOG_CYC < 1) begin : g_bad_param
        $error("fifo_write_arbiter: illegal parameter combination");
    end

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state, state_nxt;
    logic [N_REQ-1:0] gnt_nxt;
    logic [GNT_W-1:0] gidx, gidx_nxt;
    logic [GNT_W-1:0] rr_ptr, rr_nxt;
    logic [GNT_W-1:0] pick_idx, cand;
    logic             found;
    logic             g_valid, g_last;
    logic             accept;
    logic             wdog_trip;

    // Circular search starting just after the previous winner.
    always_comb begin
        found    = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = GNT_W'((int'(rr_ptr) + k) % N_REQ);
            if (!found && req_valid[cand]) begin
                found    = 1'b1;
                pick_idx = cand;
            end
        end
    end

    assign g_valid = req_valid[gidx];
    assign g_last  = req_last[gidx];
    assign busy    = (state == BUSY);
    assign accept  = busy & g_valid & ~wfull;

    always_comb begin
        winc    = accept;
        req_ack = accept ? gnt : '0;
        wdata   = busy ? req_data[int'(gidx)*DATA_W +: DATA_W] : '0;
    end

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        gidx_nxt  = gidx;
        rr_nxt    = rr_ptr;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt = BUSY;
                    gidx_nxt  = pick_idx;
                    gnt_nxt   = N_REQ'(1) << pick_idx;
                end
            end
            BUSY: begin
                if ((accept && g_last) || wdog_trip) begin
                    state_nxt = IDLE;
                    gnt_nxt   = '0;
                    rr_nxt    = gidx;
                end
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            gnt    <= '0;
            gidx   <= '0;
            rr_ptr <= GNT_W'(N_REQ - 1);
        end else begin
            state  <= state_nxt;
            gnt    <= gnt_nxt;
            gidx   <= gidx_nxt;
            rr_ptr <= rr_nxt;
        end
    end

`ifdef ARB_WDOG_EN
    localparam int WDOG_W = $clog2(WDOG_CYC + 1);

    logic [WDOG_W-1:0] stall_cnt, stall_nxt;
    logic              wdog_err_q;

    // Only a silent owner with room in the FIFO counts as a stall.
    always_comb begin
        stall_nxt = '0;
        wdog_trip = 1'b0;
        if (busy && !g_valid && !wfull) begin
            if (stall_cnt == WDOG_W'(WDOG_CYC - 1)) begin
                wdog_trip = 1'b1;
            end else begin
                stall_nxt = stall_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt  <= '0;
            wdog_err_q <= 1'b0;
        end else begin
            stall_cnt  <= stall_nxt;
            wdog_err_q <= wdog_trip;
        end
    end

    assign wdog_err = wdog_err_q;
`else
    assign wdog_trip = 1'b0;
    assign wdog_err  = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Testbench for fifo_write_arbiter: directed scenarios plus randomized traffic against a packet-level model.
// Build with ARB_WDOG_EN defined to exercise the stall watchdog.

module tb_fifo_write_arbiter;

    localparam int N_REQ    = 4;
    localparam int DATA_W   = 8;
    localparam int GNT_W    = 2;
    localparam int WDOG_CYC = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid, req_last;
    logic [31:0] req_data;
    logic        wfull;
    logic [3:0]  req_ack, gnt;
    logic        winc;
    logic [7:0]  wdata;
    logic        busy, wdog_err;

    int n_tests = 0;
    int n_fail  = 0;

    // packet-level model: who owns the port, who won last
    int m_owner;
    int m_ptr;
    int m_stall;
    bit m_wdog;
    int m_acc;
    int n_writes;

    // random stimulus bookkeeping
    bit         pend [4];
    int         left [4];
    logic [7:0] dat  [4];

    always #5 clk = ~clk;

    fifo_write_arbiter #(
        .N_REQ(N_REQ), .DATA_W(DATA_W), .GNT_W(GNT_W), .WDOG_CYC(WDOG_CYC)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
        .wfull(wfull),
        .req_ack(req_ack), .gnt(gnt), .winc(winc), .wdata(wdata),
        .busy(busy), .wdog_err(wdog_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = N_REQ - 1;
        m_stall = 0;
        m_wdog  = 1'b0;
        m_acc   = -1;
    endtask

    task automatic compare_all();
        logic [3:0] e_gnt, e_ack;
        logic       e_acc;
        logic [7:0] e_wdata;
        e_gnt = 4'b0; e_ack = 4'b0; e_acc = 1'b0; e_wdata = 8'h00;
        if (m_owner >= 0) begin
            e_gnt   = 4'(1 << m_owner);
            e_acc   = req_valid[m_owner] && !wfull;
            e_ack   = e_acc ? e_gnt : 4'b0;
            e_wdata = req_data[m_owner*8 +: 8];
        end
        chk("gnt",      32'(gnt),      32'(e_gnt));
        chk("busy",     32'(busy),     32'(m_owner >= 0));
        chk("winc",     32'(winc),     32'(e_acc));
        chk("req_ack",  32'(req_ack),  32'(e_ack));
        chk("wdata",    32'(wdata),    32'(e_wdata));
        chk("wdog_err", 32'(wdog_err), 32'(m_wdog));
    endtask

    task automatic model_tick();
        m_wdog = 1'b0;
        m_acc  = -1;
        if (rst) begin
            model_reset();
            return;
        end
        if (m_owner < 0) begin
            for (int k = 1; k <= N_REQ; k++) begin
                int c;
                c = (m_ptr + k) % N_REQ;
                if (req_valid[c]) begin
                    m_owner = c;
                    m_stall = 0;
                    break;
                end
            end
        end else if (req_valid[m_owner] && !wfull) begin
            m_acc = m_owner;
            n_writes++;
            m_stall = 0;
            if (req_last[m_owner]) begin
                m_ptr   = m_owner;
                m_owner = -1;
            end
        end else if (wfull) begin
            m_stall = 0;
        end else begin
            m_stall++;
`ifdef ARB_WDOG_EN
            if (m_stall == WDOG_CYC) begin
                m_ptr   = m_owner;
                m_owner = -1;
                m_wdog  = 1'b1;
                m_stall = 0;
            end
`endif
        end
    endtask

    // inputs are set at the negedge; compare just after, advance model on the posedge
    task automatic step();
        #1;
        compare_all();
        @(posedge clk);
        model_tick();
        if (m_acc >= 0) begin
            pend[m_acc] = 1'b0;
            left[m_acc]--;
        end
        @(negedge clk);
    endtask

    task automatic drv(input logic [3:0] v, input logic [3:0] l, input logic [31:0] d, input logic f);
        req_valid = v;
        req_last  = l;
        req_data  = d;
        wfull     = f;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drv(4'b0, 4'b0, 32'h0, 1'b0);
        model_reset();
        #1;
        chk("rst_gnt",  32'(gnt),     32'h0);
        chk("rst_busy", 32'(busy),    32'h0);
        chk("rst_winc", 32'(winc),    32'h0);
        chk("rst_ack",  32'(req_ack), 32'h0);
        chk("rst_wdata",32'(wdata),   32'h0);
        chk("rst_wdog", 32'(wdog_err),32'h0);
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        drv(4'b0, 4'b0, 32'h0, 1'b0);
        n_writes = 0;
        for (int r = 0; r < 4; r++) begin pend[r] = 1'b0; left[r] = 0; dat[r] = 8'h00; end
        do_reset();

        // single requester, 3 beats
        drv(4'b0001, 4'b0000, 32'h0000_00A1, 1'b0);
        #1 chk("t1_idle_nowrite", 32'(winc), 32'h0);
        step();
        #1 chk("t1_gnt", 32'(gnt), 32'h1);
        chk("t1_wdata1", 32'(wdata), 32'hA1);
        step();
        drv(4'b0001, 4'b0000, 32'h0000_00A2, 1'b0);
        #1 chk("t1_wdata2", 32'(wdata), 32'hA2);
        chk("t1_winc2", 32'(winc), 32'h1);
        step();
        drv(4'b0001, 4'b0001, 32'h0000_00A3, 1'b0);
        #1 chk("t1_wdata3", 32'(wdata), 32'hA3);
        step();
        drv(4'b0000, 4'b0000, 32'h0, 1'b0);
        #1 chk("t1_busy_drop", 32'(busy), 32'h0);
        step();

        // round robin from reset, all single-beat
        do_reset();
        drv(4'b1111, 4'b1111, 32'h1312_1110, 1'b0);
        for (int k = 0; k < 10; k++) begin
            #1;
            if (k % 2 == 0) begin
                chk("t2_gap", 32'(winc), 32'h0);
            end else begin
                chk("t2_order", 32'(gnt), 32'(1 << ((k / 2) % 4)));
                chk("t2_wdata", 32'(wdata), 32'(8'h10 + (k / 2) % 4));
            end
            step();
        end

        // back-pressure on the last beat of requester 2
        drv(4'b0100, 4'b0000, 32'h00B1_0000, 1'b0);
        step();
        #1 chk("t3_gnt", 32'(gnt), 32'h4);
        chk("t3_wdata1", 32'(wdata), 32'hB1);
        step();
        for (int k = 0; k < 3; k++) begin
            drv(4'b0100, 4'b0100, 32'h00B2_0000, 1'b1);
            #1 chk("t3_full_nowinc", 32'(winc), 32'h0);
            chk("t3_full_gnt", 32'(gnt), 32'h4);
            step();
        end
        drv(4'b0100, 4'b0100, 32'h00B2_0000, 1'b0);
        #1 chk("t3_retry_winc", 32'(winc), 32'h1);
        chk("t3_retry_wdata", 32'(wdata), 32'hB2);
        step();
        drv(4'b0000, 4'b0000, 32'h0, 1'b0);
        #1 chk("t3_idle", 32'(busy), 32'h0);
        step();

        // contention while requester 1 holds the grant
        drv(4'b0010, 4'b0000, 32'h0000_C100, 1'b0);
        step();
        #1 chk("t4_gnt1", 32'(gnt), 32'h2);
        step();
        drv(4'b1010, 4'b1000, 32'hD100_C200, 1'b0);
        #1 chk("t4_ack_c2", 32'(req_ack), 32'h2);
        step();
        drv(4'b1010, 4'b1010, 32'hD100_C300, 1'b0);
        #1 chk("t4_ack_c3", 32'(req_ack), 32'h2);
        step();
        drv(4'b1000, 4'b1000, 32'hD100_0000, 1'b0);
        #1 chk("t4_gap", 32'(gnt), 32'h0);
        step();
        #1 chk("t4_gnt3", 32'(gnt), 32'h8);
        chk("t4_ack3", 32'(req_ack), 32'h8);
        step();
        drv(4'b0000, 4'b0000, 32'h0, 1'b0);
        step();

        // async reset in the middle of requester 1's packet
        drv(4'b0001, 4'b0001, 32'h0000_00E0, 1'b0);
        step();
        step();
        drv(4'b0010, 4'b0000, 32'h0000_E100, 1'b0);
        step();
        #1 chk("t5_gnt1", 32'(gnt), 32'h2);
        step();
        drv(4'b0010, 4'b0000, 32'h0000_E200, 1'b0);
        #1 chk("t5_pre_winc", 32'(winc), 32'h1);
        #1 rst = 1'b1;
        model_reset();
        #1 chk("t5_rst_gnt", 32'(gnt), 32'h0);
        chk("t5_rst_busy", 32'(busy), 32'h0);
        chk("t5_rst_winc", 32'(winc), 32'h0);
        step();
        rst = 1'b0;
        drv(4'b1111, 4'b1111, 32'h4433_2211, 1'b0);
        #1 chk("t5_idle", 32'(gnt), 32'h0);
        step();
        #1 chk("t5_prio0", 32'(gnt), 32'h1);
        step();
        drv(4'b0000, 4'b0000, 32'h0, 1'b0);
        step();
        step();

        // owner goes silent after its first beat
        do_reset();
        drv(4'b0011, 4'b0010, 32'h0000_F2F1, 1'b0);
        step();
        #1 chk("t6_gnt0", 32'(gnt), 32'h1);
        step();
        drv(4'b0010, 4'b0010, 32'h0000_F200, 1'b0);
`ifdef ARB_WDOG_EN
        for (int j = 0; j < 20; j++) begin
            #1 chk("t6_wdog", 32'(wdog_err), 32'(j == 16));
            if (j == 16) chk("t6_released", 32'(gnt), 32'h0);
            if (j == 17) chk("t6_next_rr", 32'(gnt), 32'h2);
            step();
        end
`else
        for (int j = 0; j < 20; j++) begin
            #1 chk("t6_held", 32'(gnt), 32'h1);
            chk("t6_wdog0", 32'(wdog_err), 32'h0);
            step();
        end
        drv(4'b0001, 4'b0001, 32'h0000_00F3, 1'b0);
        step();
`endif
        drv(4'b0000, 4'b0000, 32'h0, 1'b0);
        step();
        step();

        // randomized traffic
        do_reset();
        n_writes = 0;
        for (int r = 0; r < 4; r++) begin pend[r] = 1'b0; left[r] = 0; end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int r = 0; r < 4; r++) begin
                if (!pend[r] && $urandom_range(0, 99) < 50) begin
                    pend[r] = 1'b1;
                    if (left[r] <= 0) left[r] = $urandom_range(1, 4);
                    dat[r] = 8'($urandom);
                end
                req_valid[r] = pend[r];
                req_last[r]  = pend[r] ? (left[r] == 1) : 1'($urandom);
                req_data[r*8 +: 8] = pend[r] ? dat[r] : 8'($urandom);
            end
            wfull = ($urandom_range(0, 99) < 30);
            step();
        end
        n_tests++;
        if (n_writes < 100) begin
            n_fail++;
            $display("FAIL rand_activity: got %0d writes expected at least 100", n_writes);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
- Shares the write port of one router FIFO (fifo_write_logic: winc in, wfull out) between N_REQ input requesters.
- Grants whole packets in round-robin order. Once a packet is granted, the grant is held until its last beat has been written.
- Gates every beat with wfull, so no write is ever issued into a full FIFO.
- Produces winc/wdata for the FIFO and a per-requester ack.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DATA_W, 8, data width of one beat.
- GNT_W, 2, width of the grant index; must equal ceil(log2(N_REQ)).
- WDOG_CYC, 16, stall limit used only when ARB_WDOG_EN is defined.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous active-high reset.
- req_valid  in  N_REQ  per-requester beat valid.
- req_last  in  N_REQ  per-requester end-of-packet flag, qualified by req_valid.
- req_data  in  N_REQ*DATA_W  flattened data; requester i occupies bits [i*DATA_W +: DATA_W].
- wfull  in  1  full flag from the FIFO write logic.
- req_ack  out  N_REQ  one-hot; beat of requester i accepted this cycle.
- gnt  out  N_REQ  one-hot registered grant; zero when idle.
- winc  out  1  FIFO write increment.
- wdata  out  DATA_W  FIFO write data.
- busy  out  1  high while a packet grant is held.
- wdog_err  out  1  watchdog release pulse (tied 0 without ARB_WDOG_EN).

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; gnt=0; busy=0; wdog_err=0.
  - rr_ptr=N_REQ-1, so requester 0 has first priority after reset.
  - Combinational outputs are 0 while in reset: winc=0, req_ack=0, wdata=0.
- FSM has two states, IDLE and BUSY.
- IDLE:
  - If any req_valid is high, select the first requester with valid high, searching circularly from rr_ptr+1.
  - Register its one-hot grant into gnt, set busy=1, go to BUSY.
  - No beat is accepted in the IDLE cycle: arbitration latency is 1 clock from req_valid to the first possible write.
  - If no req_valid is high, stay in IDLE.
- BUSY, granted index g:
  - accept = req_valid[g] & ~wfull.
  - winc = accept; req_ack[g] = accept; wdata = req_data[g] whenever busy, else 0. All three are combinational.
- accept & req_last[g]:
  - Next cycle: state=IDLE, gnt=0, busy=0, rr_ptr=g.
  - A new arbitration occurs in that IDLE cycle. Minimum gap between packets is 1 idle cycle.
- Single-beat packets are legal: valid and last are both high on the first BUSY cycle.
- wfull=1 in BUSY:
  - No ack and no winc; the grant is held.
  - The beat, including its last flag, is retried on the first cycle with wfull=0.
- Grant holding:
  - Non-granted requesters' valid/last are ignored and never acked.
  - The granted requester dropping valid mid-packet does not release the grant (absent the watchdog).
- Requester obligation: a requester holds data/last stable while valid and not acked. The arbiter does not check this.
- Fairness: a requester that keeps requesting waits at most N_REQ-1 packets.
- Async reset mid-packet: grant is dropped immediately, and the partial packet stays in the FIFO. Upstream is responsible for recovery.

Optional Feature:
- Macro: ARB_WDOG_EN.
- Defined:
  - A stall counter (width ceil(log2(WDOG_CYC+1))) counts BUSY cycles with req_valid[g]=0 and wfull=0.
  - The counter clears on any accept, and on any cycle where wfull=1.
  - When the count reaches WDOG_CYC: go to IDLE, gnt=0, rr_ptr=g, and pulse wdog_err=1 for exactly one cycle.
- Not defined: no counter; wdog_err is constant 0; a stalled grant is held indefinitely.

Test Plan:
- Reset then single requester: req_valid=0001, 3 beats (data 0xA1, 0xA2, 0xA3), last on the third, wfull=0.
  -> gnt=0001 one cycle after valid; winc high for 3 consecutive cycles; wdata=A1,A2,A3; busy drops the cycle after the last ack.
- Round robin: all 4 requesting 1-beat packets continuously, starting from reset.
  -> grant order 0,1,2,3,0; exactly one winc per grant; one idle cycle between grants.
- Full back-pressure: requester 2 sends a 2-beat packet; wfull=1 for 3 cycles during beat 2 (last).
  -> no winc/ack during those 3 cycles; gnt stays 0100; beat 2 written on the first cycle wfull=0; then IDLE.
- Mid-packet contention: requester 1 granted and sends beat 1 of 3; requester 3 raises valid.
  -> req_ack[3]=0 until requester 1's last beat; then gnt=1000.
- Async reset mid-packet: assert rst between clock edges during beat 2 of 4.
  -> gnt=0, busy=0, winc=0 immediately; after release, requester 0 has priority.
- With ARB_WDOG_EN and WDOG_CYC=16: granted requester drops valid for 16 cycles with wfull=0.
  -> wdog_err is a single 1-cycle pulse; gnt=0; the next requester in round-robin order is granted afterwards.
